// File: rtl/register_8bit_pkg.sv
// Shared constants for the register_8bit storage element and its users.
// No logic; constants only.
// No flow control.
package register_8bit_pkg;

  // Default datapath width for plain storage registers in this slice.
  localparam int unsigned REG_DATA_W = 8;

endpackage

// File: rtl/register_8bit.sv
// Parallel-load data register with synchronous active-high reset and load enable.
// Latency: one clk edge from data_in/load (or sync_rst) to data_out.
// No backpressure: load is a plain qualifier with no acknowledge.
module register_8bit
  import register_8bit_pkg::*;
#(
  parameter int unsigned      WIDTH   = REG_DATA_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_q;

  // Storage flop: reset beats load, otherwise hold.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      data_q <= RST_VAL;
    end else if (load) begin
      data_q <= data_in;
    end
  end

  // Output comes straight from the flops, so there is no input-to-output path.
  assign data_out = data_q;

endmodule

// File: tb/tb_register_8bit.sv
// Self-checking bench for register_8bit: directed cases then random traffic.
// Checks one time unit after each rising edge and again at the falling edge.
// No flow control on this block.
module tb_register_8bit;

  localparam int unsigned W = 8;

  logic         clk;
  logic         sync_rst;
  logic         load;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;

  int chk_cnt;
  int pass_cnt;

  // Reference: the value last accepted by the register. It is written with
  // the meaning of each edge (clear / capture / keep), not as a flop model.
  logic [W-1:0] ref_val;

  register_8bit #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .load     (load),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: data_out=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one edge worth of inputs, then check right after the edge and
  // again at mid-cycle with data_in disturbed to prove nothing leaks through.
  task automatic step(input string tag, input logic r, input logic l, input logic [W-1:0] d);
    sync_rst = r;
    load     = l;
    data_in  = d;
    @(posedge clk);
    if (r)      ref_val = '0;
    else if (l) ref_val = d;
    #1;
    check({tag, "_edge"}, data_out, ref_val);
    data_in = W'($urandom);
    @(negedge clk);
    check({tag, "_mid"}, data_out, ref_val);
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    ref_val  = '0;
    sync_rst = 1'b0;
    load     = 1'b0;
    data_in  = '0;
    @(negedge clk);

    // Directed cases
    step("reset",       1'b1, 1'b0, 8'h00);
    step("load_aa",     1'b0, 1'b1, 8'hAA);
    step("hold_ff_0",   1'b0, 1'b0, 8'hFF);
    step("hold_ff_1",   1'b0, 1'b0, 8'hFF);
    step("rst_prio",    1'b1, 1'b1, 8'h55);
    step("reload_55",   1'b0, 1'b1, 8'h55);
    step("hold_55",     1'b0, 1'b0, 8'h00);
    step("b2b_01",      1'b0, 1'b1, 8'h01);
    step("b2b_80",      1'b0, 1'b1, 8'h80);
    step("b2b_ff",      1'b0, 1'b1, 8'hFF);
    step("rst_release", 1'b1, 1'b0, 8'h3C);
    step("load_after",  1'b0, 1'b1, 8'hC3);

    // Random traffic: occasional reset, frequent load and hold
    for (int i = 0; i < 300; i++) begin
      step("rand",
           ($urandom_range(15) == 0),
           ($urandom_range(1) == 1),
           W'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
